// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR output stage.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fir_state_e;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned OUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/fir_out_fifo.sv
// Parameterized synchronous FIFO with wrap-bit pointers; head is read straight from storage.
module fir_out_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_axis_out.sv
// FIR output stage: buffers finished y samples and streams them out on AXI-Stream with
// tlast on the final sample, raising a sticky ap_done when the frame completes.
module fir_axis_out
    import fir_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = DATA_W,
    parameter int unsigned FIFO_DEPTH  = OUT_FIFO_DEPTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   y_valid,
    input  logic [pDATA_WIDTH-1:0] y_data,
    output logic                   y_ready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   done_clr,
    output logic                   ap_done,
    output logic                   busy
);

    localparam logic [pDATA_WIDTH-1:0] CntOne = 1;

    fir_state_e             state_q, state_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic [pDATA_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                   ap_done_q, ap_done_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [pDATA_WIDTH-1:0] fifo_dout;
    logic                   push;
    logic                   pop;
    logic                   last_out;

    fir_out_fifo #(
        .WIDTH (pDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .push       (push),
        .pop        (pop),
        .din        (y_data),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign y_ready   = (state_q == RUN) && !fifo_full && (in_cnt_q < len_q);
    assign sm_tvalid = !fifo_empty;
    assign sm_tdata  = fifo_empty ? '0 : fifo_dout;
    assign last_out  = (out_cnt_q == len_q - CntOne);
    assign sm_tlast  = sm_tvalid && last_out;
    assign push      = y_valid && y_ready;
    assign pop       = sm_tvalid && sm_tready;
    assign ap_done   = ap_done_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ap_done_d = ap_done_q && !done_clr;

        if (push) in_cnt_d  = in_cnt_q + CntOne;
        if (pop)  out_cnt_d = out_cnt_q + CntOne;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = data_length;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (data_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && last_out) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set on the DONE entry edge; overrides a coincident clear.
        if (state_d == DONE && state_q != DONE) ap_done_d = 1'b1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ap_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ap_done_q <= ap_done_d;
        end
    end

endmodule
